// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_pkg
// Description : Shared FSM encoding, requester ids and defaults for the
//               data-memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic ID_CORE         = 1'b0;
    localparam logic ID_IO           = 1'b1;
    localparam int   DEFAULT_TIMEOUT = 255;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Combinational two-way round-robin grant; on a tie the
//               requester that was not served last wins.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic core_req,
    input  logic io_req,
    input  logic last_gnt,
    output logic gnt_valid,
    output logic gnt_id
);

    assign gnt_valid = core_req | io_req;

    always_comb begin
        gnt_id = ID_CORE;
        if (core_req && io_req) begin
            gnt_id = ~last_gnt;
        end else if (io_req) begin
            gnt_id = ID_IO;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_port_arbiter
// Description : Registered round-robin sharing of the data-memory port
//               between the core MEM stage and the IO loader. Optional WAIT
//               timeout abort is enabled by defining DMEM_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_done,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              io_req,
    input  logic              io_we,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    output logic              io_done,
    output logic [DATA_W-1:0] io_rdata,
    output logic              mem_valid,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    input  logic              mem_ready,
    output logic              busy,
    output logic              err
);

    state_t            r_state;
    logic              r_gnt_id;
    logic              r_last_gnt;
    logic              r_rw;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_din;
    logic [DATA_W-1:0] r_core_rdata;
    logic [DATA_W-1:0] r_io_rdata;
    logic              r_core_done;
    logic              r_io_done;

    logic              w_gnt_valid;
    logic              w_gnt_id;
    logic              w_sel_io;

    rr_arb2 u_rr_arb2 (
        .core_req  (core_req),
        .io_req    (io_req),
        .last_gnt  (r_last_gnt),
        .gnt_valid (w_gnt_valid),
        .gnt_id    (w_gnt_id)
    );

    assign w_sel_io = (w_gnt_id == ID_IO);

`ifdef DMEM_ARB_TIMEOUT_EN
    localparam int c_cnt_w = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_err;
    assign err = r_err;
`else
    localparam logic c_unused_timeout_ok = (TIMEOUT >= 1);
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_gnt_id     <= ID_CORE;
            r_last_gnt   <= ID_IO;
            r_rw         <= 1'b0;
            r_addr       <= '0;
            r_din        <= '0;
            r_core_rdata <= '0;
            r_io_rdata   <= '0;
            r_core_done  <= 1'b0;
            r_io_done    <= 1'b0;
`ifdef DMEM_ARB_TIMEOUT_EN
            r_cnt        <= '0;
            r_err        <= 1'b0;
`endif
        end else begin
            r_core_done <= 1'b0;
            r_io_done   <= 1'b0;
`ifdef DMEM_ARB_TIMEOUT_EN
            r_err       <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_gnt_valid) begin
                        r_gnt_id <= w_gnt_id;
                        r_rw     <= w_sel_io ? io_we    : core_we;
                        r_addr   <= w_sel_io ? io_addr  : core_addr;
                        r_din    <= w_sel_io ? io_wdata : core_wdata;
                        r_state  <= WAIT;
`ifdef DMEM_ARB_TIMEOUT_EN
                        r_cnt    <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (mem_ready) begin
                        if (!r_rw) begin
                            if (r_gnt_id == ID_IO) r_io_rdata   <= mem_dout;
                            else                   r_core_rdata <= mem_dout;
                        end
                        r_last_gnt  <= r_gnt_id;
                        r_core_done <= (r_gnt_id == ID_CORE);
                        r_io_done   <= (r_gnt_id == ID_IO);
                        r_state     <= DONE;
                    end
`ifdef DMEM_ARB_TIMEOUT_EN
                    // Abort lands DONE on the TIMEOUT-th WAIT cycle after grant.
                    else if (r_cnt == c_cnt_w'(TIMEOUT - 1)) begin
                        if (!r_rw) begin
                            if (r_gnt_id == ID_IO) r_io_rdata   <= '0;
                            else                   r_core_rdata <= '0;
                        end
                        r_last_gnt  <= r_gnt_id;
                        r_core_done <= (r_gnt_id == ID_CORE);
                        r_io_done   <= (r_gnt_id == ID_IO);
                        r_err       <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Decoded from the state register so the async reset drops them at once.
    assign mem_valid  = (r_state == WAIT);
    assign busy       = (r_state != IDLE);
    assign mem_rw     = r_rw;
    assign mem_addr   = r_addr;
    assign mem_din    = r_din;
    assign core_done  = r_core_done;
    assign io_done    = r_io_done;
    assign core_rdata = r_core_rdata;
    assign io_rdata   = r_io_rdata;

endmodule
`default_nettype wire
